// File: rtl/arb_rr_hold.sv
`default_nettype none
// ============================================================================
//  Module   : arb_rr_hold
//  Brief    : N-way round-robin arbiter granting exclusive multi-cycle
//             ownership. The owner keeps the registered one-hot grant until it
//             pulses done or drops its request. The priority pointer then moves
//             past the released owner, and one idle cycle separates owners.
//  Options  : ARB_TIMEOUT_EN - when defined, an owner that has held for
//             MAX_HOLD cycles is force-released while another requester waits,
//             and timeout pulses for one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_rr_hold #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           timeout
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam logic [N-1:0]   ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0] LAST_IDX = IDW'(N - 1);

    // Reject unsupported configurations during elaboration
    if ((N < 2) || (N > 16)) begin : g_bad_n
        $error("arb_rr_hold: N must be in the range 2..16");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("arb_rr_hold: MAX_HOLD must be at least 1");
    end

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q,   gnt_d;
    logic [IDW-1:0] id_q,    id_d;
    logic [IDW-1:0] ptr_q,   ptr_d;

    logic           w_found;
    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_idx;
    logic           w_release;
    logic           w_force;

    // Pick the first requester at or above ptr, wrapping modulo N
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
            w_idx = (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
        end
    end

    // Only the current owner's req/done can end ownership
    assign w_release = (state_q == ST_OWN) && (!req[id_q] || done[id_q]);

`ifdef ARB_TIMEOUT_EN
    localparam int            CW       = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // A normal release on the same edge takes precedence over a forced one
    assign w_force = (state_q == ST_OWN) && !w_release &&
                     (cnt_q == HOLD_MAX) && (|(req & ~gnt_q));
    assign timeout = timeout_q;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    // Next-state logic: grant on arbitration, clear and advance ptr on release
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    state_d = ST_OWN;
                    gnt_d   = ONE_HOT0 << w_win;
                    id_d    = w_win;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = HOLD_ONE;
`endif
                end
            end
            ST_OWN: begin
                if (w_release || w_force) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    id_d    = '0;
                    ptr_d   = (id_q == LAST_IDX) ? '0 : id_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = '0;
                    timeout_d = w_force;
                end else if (cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                id_d    = '0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == ST_OWN);
    assign gnt_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_rr_hold.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arb_rr_hold
//  Brief    : Self-checking bench for arb_rr_hold: reset behaviour, a table of
//             hand-derived vectors, random traffic against a reference model,
//             asynchronous reset mid-ownership and (with ARB_TIMEOUT_EN) the
//             forced-release sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arb_rr_hold;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic [N-1:0] req  = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         timeout;

    arb_rr_hold #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] id;
    } vec_t;

    vec_t vt[$];

    // Reference model: owner index (-1 when idle), priority pointer, hold count
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_hold  = 0;
    logic m_to    = 1'b0;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic [3:0] d);
        logic [3:0] others;
        int         k;
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (m_owner < 0 && r[k]) begin
                    m_owner = k;
                    m_hold  = 1;
                end
            end
        end else if (!r[m_owner] || d[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_hold  = 0;
        end else begin
            others          = r;
            others[m_owner] = 1'b0;
`ifdef ARB_TIMEOUT_EN
            if (m_hold >= MAX_HOLD && others != 4'b0000) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_hold  = 0;
                m_to    = 1'b1;
            end else if (m_hold < MAX_HOLD) begin
                m_hold = m_hold + 1;
            end
`else
            m_hold = m_hold + ((others != 4'b0000) ? 1 : 1);
`endif
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                              input logic to);
        check({tag, ".gnt"},       32'(gnt),       32'(g));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(|g));
        check({tag, ".gnt_id"},    32'(gnt_id),    32'(id));
        check({tag, ".timeout"},   32'(timeout),   32'(to));
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eg;
        logic [1:0] eid;
        eg  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        eid = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        expect_out(tag, eg, eid, m_to);
    endtask

    // One clock: apply inputs, advance the model with them, compare after the edge
    task automatic step(input logic [3:0] r, input logic [3:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        check_model("model");
    endtask

    task automatic reset_dut();
        req  = '0;
        done = '0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [3:0] rr;
        logic [3:0] dd;

        // req, done, expected gnt, expected id (ptr=0 after reset)
        vt.push_back(vec_t'{4'b1111, 4'b0000, 4'b0001, 2'd0});
        vt.push_back(vec_t'{4'b1111, 4'b0001, 4'b0000, 2'd0});
        vt.push_back(vec_t'{4'b0000, 4'b0000, 4'b0000, 2'd0});
        for (int i = 0; i < 5; i++)
            vt.push_back(vec_t'{4'b0001, 4'b0000, 4'b0001, 2'd0});
        vt.push_back(vec_t'{4'b0001, 4'b0001, 4'b0000, 2'd0});
        vt.push_back(vec_t'{4'b0000, 4'b0000, 4'b0000, 2'd0});
        vt.push_back(vec_t'{4'b1000, 4'b0000, 4'b1000, 2'd3});
        vt.push_back(vec_t'{4'b0000, 4'b0000, 4'b0000, 2'd0});
        vt.push_back(vec_t'{4'b1111, 4'b0000, 4'b0001, 2'd0});
        vt.push_back(vec_t'{4'b1111, 4'b0000, 4'b0001, 2'd0});
        vt.push_back(vec_t'{4'b1111, 4'b0001, 4'b0000, 2'd0});
        vt.push_back(vec_t'{4'b1111, 4'b0000, 4'b0010, 2'd1});
        vt.push_back(vec_t'{4'b1111, 4'b0000, 4'b0010, 2'd1});
        vt.push_back(vec_t'{4'b1111, 4'b0010, 4'b0000, 2'd0});
        vt.push_back(vec_t'{4'b1111, 4'b0000, 4'b0100, 2'd2});
        vt.push_back(vec_t'{4'b1111, 4'b0000, 4'b0100, 2'd2});
        vt.push_back(vec_t'{4'b1111, 4'b0100, 4'b0000, 2'd0});
        vt.push_back(vec_t'{4'b1111, 4'b0000, 4'b1000, 2'd3});
        vt.push_back(vec_t'{4'b1111, 4'b0000, 4'b1000, 2'd3});
        vt.push_back(vec_t'{4'b1111, 4'b1000, 4'b0000, 2'd0});
        vt.push_back(vec_t'{4'b1111, 4'b0000, 4'b0001, 2'd0});
        vt.push_back(vec_t'{4'b0011, 4'b0001, 4'b0000, 2'd0});
        vt.push_back(vec_t'{4'b0011, 4'b0000, 4'b0010, 2'd1});
        vt.push_back(vec_t'{4'b0011, 4'b0100, 4'b0010, 2'd1});
        vt.push_back(vec_t'{4'b0011, 4'b0010, 4'b0000, 2'd0});
        vt.push_back(vec_t'{4'b0011, 4'b0100, 4'b0001, 2'd0});
        vt.push_back(vec_t'{4'b0001, 4'b0000, 4'b0001, 2'd0});
        vt.push_back(vec_t'{4'b0000, 4'b0001, 4'b0000, 2'd0});
        vt.push_back(vec_t'{4'b0101, 4'b0000, 4'b0100, 2'd2});
        vt.push_back(vec_t'{4'b0111, 4'b0000, 4'b0100, 2'd2});
        vt.push_back(vec_t'{4'b0101, 4'b0000, 4'b0100, 2'd2});
        vt.push_back(vec_t'{4'b0001, 4'b0000, 4'b0000, 2'd0});
        vt.push_back(vec_t'{4'b0001, 4'b0000, 4'b0001, 2'd0});
        vt.push_back(vec_t'{4'b0000, 4'b0000, 4'b0000, 2'd0});

        // Reset held for three edges with every requester active
        rst  = 1'b1;
        req  = 4'b1111;
        done = 4'b0000;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            expect_out("reset", 4'b0000, 2'd0, 1'b0);
        end
        rst = 1'b0;

        // Hand-derived vectors, first entry is the first grant after reset
        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].req, vt[i].done);
            expect_out($sformatf("vec%0d", i), vt[i].gnt, vt[i].id, 1'b0);
        end

        // Random traffic against the model; requests change occasionally
        rr = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0)
                rr = 4'($urandom_range(0, 15));
            dd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step(rr, dd);
        end

        // Asynchronous reset while requester 2 owns the resource
        reset_dut();
        step(4'b0100, 4'b0000);
        expect_out("own2", 4'b0100, 2'd2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expect_out("async_rst", 4'b0000, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        expect_out("async_rst_hold", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        model_reset();
        step(4'b1000, 4'b0000);
        expect_out("post_rst_own3", 4'b1000, 2'd3, 1'b0);
        step(4'b1000, 4'b1000);
        expect_out("post_rst_rel3", 4'b0000, 2'd0, 1'b0);
        step(4'b1111, 4'b0000);
        expect_out("ptr_wrap0", 4'b0001, 2'd0, 1'b0);
        step(4'b0000, 4'b0000);

`ifdef ARB_TIMEOUT_EN
        // Forced release after MAX_HOLD cycles with a competitor waiting
        reset_dut();
        step(4'b0001, 4'b0000);
        expect_out("to_c1", 4'b0001, 2'd0, 1'b0);
        for (int c = 2; c <= MAX_HOLD; c++) begin
            step((c >= 4) ? 4'b0101 : 4'b0001, 4'b0000);
            expect_out($sformatf("to_c%0d", c), 4'b0001, 2'd0, 1'b0);
        end
        step(4'b0101, 4'b0000);
        expect_out("to_force", 4'b0000, 2'd0, 1'b1);
        step(4'b0101, 4'b0000);
        expect_out("to_next", 4'b0100, 2'd2, 1'b0);
        step(4'b0001, 4'b0000);
        expect_out("to_rel2", 4'b0000, 2'd0, 1'b0);

        // Alone, the owner is never released; a late competitor forces release
        step(4'b0001, 4'b0000);
        for (int c = 0; c < 40; c++) begin
            step(4'b0001, 4'b0000);
            expect_out("sat_hold", 4'b0001, 2'd0, 1'b0);
        end
        step(4'b0101, 4'b0000);
        expect_out("sat_force", 4'b0000, 2'd0, 1'b1);
        step(4'b0000, 4'b0000);
        expect_out("sat_idle", 4'b0000, 2'd0, 1'b0);
`else
        // Without the timeout option an owner holds indefinitely
        reset_dut();
        step(4'b0001, 4'b0000);
        for (int c = 0; c < 40; c++) begin
            step(4'b0101, 4'b0000);
            expect_out("hold_forever", 4'b0001, 2'd0, 1'b0);
        end
        step(4'b0100, 4'b0000);
        expect_out("hold_rel", 4'b0000, 2'd0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arb_rr_hold.md
Name: arb_rr_hold

Overview:
- N-way round-robin arbiter that grants one requester exclusive, multi-cycle ownership of a shared resource.
- Ownership lasts until the owner signals completion or drops its request.
- Grants are registered and one-hot. Fairness rotates a priority pointer past each released owner.
- Sits between the requesting agents and the shared resource's select/mux logic.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 16, maximum ownership cycles before forced release (used only with ARB_TIMEOUT_EN); must be >= 1.
- IDW, $clog2(N), width of gnt_id.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N  request per requester; level, held while ownership is wanted.
- done  input  N  per-requester release strobe; honoured only for the current owner.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_valid  output  1  high while any gnt bit is high.
- gnt_id  output  IDW  binary index of the owner; 0 when gnt_valid=0.
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset: state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, timeout=0, ptr=0, hold counter=0. Outputs clear asynchronously on rst assertion, including mid-ownership.
- State machine has two states, IDLE and OWN.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: select the first set req bit searching from index ptr upward, wrapping modulo N.
  - The winner's gnt bit is set by the same edge that samples req. Request-to-grant latency is 1 cycle.
  - Go to OWN.
- OWN: gnt is held constant while req[owner]=1 and done[owner]=0.
- OWN release condition: req[owner]=0 or done[owner]=1 sampled at an edge. On that edge:
  - gnt=0, gnt_valid=0, gnt_id=0.
  - ptr = (owner+1) mod N.
  - Go to IDLE.
- Every handover therefore has exactly one idle cycle between owners.
- done bits of non-owners are ignored in all states. Any done bit in IDLE is ignored.
- Requests from non-owners during OWN are held pending, not latched; a requester that drops req before arbitration loses its turn.
- Releasing owner still requesting on the next IDLE cycle: it competes normally and has lowest priority, because ptr has moved past it.
- Simultaneous done[owner] and req[owner]=0: a single release.
- At most one gnt bit is high in any cycle. gnt never changes owner without an intervening all-zero cycle.
- ptr wraps from N-1 to 0.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - The hold counter counts OWN cycles, starting at 1 in the first granted cycle.
  - When count==MAX_HOLD and any other req bit is set, the owner is force-released at that edge: same effects as a normal release, plus timeout=1 for one cycle.
  - With no competing request, the counter saturates at MAX_HOLD and ownership continues. A later competing request forces release at the next edge.
  - A normal release on the same edge as a timeout is a normal release; timeout stays 0.
  - The counter clears on every release.
- Undefined: no counter is built, timeout is tied 0, and an owner may hold indefinitely.

Test Plan:
1. Assert rst for 3 cycles with req=4'b1111 -> gnt=0000, gnt_valid=0, gnt_id=0 throughout; first grant gnt=0001 one edge after rst deasserts.
2. req=0001, hold 5 cycles, then done[0]=1 for one cycle -> gnt=0001 for 5 cycles; gnt=0000 on the edge sampling done; ptr=1.
3. req=1111 held continuously, each owner pulses done after 2 granted cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, each separated by one idle cycle.
4. After owner 1 releases (ptr=2), apply req=0011 -> gnt=0001 (wrap-around); done[2]=1 from a non-owner has no effect.
5. ARB_TIMEOUT_EN, MAX_HOLD=16: req[0] held, req[2] asserted at granted cycle 3 -> gnt=0001 for 16 cycles, then 0000 with timeout=1, then gnt=0100; req[0] alone for 40 cycles -> never released, timeout stays 0.
6. Assert rst asynchronously mid-ownership (gnt=0100) -> gnt=0000 immediately; after release, req=1000 -> gnt=1000, gnt_id=3; after done[3] -> ptr=0.
